complete_stage: RTL and testbench

// - Downstream neighbour of ex_stage. Collects the four EX result streams
//   (lane1/lane2 x non_mul/mul) and broadcasts up to CDB_WIDTH results per

---
 rtl/complete_stage_pkg.sv | 36 +++
 rtl/complete_stage_cdb_fifo.sv | 80 ++++++++
 rtl/complete_stage.sv | 118 +++++++++++
 tb/tb_complete_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/complete_stage_pkg.sv
// Shared types and sizing for the completion stage and its result FIFOs.
package complete_stage_pkg;

  localparam int NUM_SRC     = 4;   // 0=lane1 non_mul, 1=lane1 mul, 2=lane2 non_mul, 3=lane2 mul
  localparam int CDB_WIDTH   = 2;   // broadcasts per cycle
  localparam int FIFO_DEPTH  = 8;   // entries per source FIFO, power of 2
  localparam int MUL_RESERVE = 4;   // free slots kept per mul FIFO for in-flight multiplies
  localparam int BRAT_SIZE   = 3;   // number of outstanding branch tags
  localparam int PRN_W       = 6;   // physical register number width

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;            // extra MSB separates full from empty
  localparam int SRC_W  = $clog2(NUM_SRC);
  localparam int GNT_W  = $clog2(CDB_WIDTH + 1);

  typedef struct packed {
    logic                 valid;
    logic [31:0]          result;
    logic [PRN_W-1:0]     dest_prn;
    logic [BRAT_SIZE-1:0] brat_vec;
  } ex_packet_t;

  typedef struct packed {
    logic                 valid;
    logic [31:0]          result;
    logic [PRN_W-1:0]     dest_prn;
    logic [BRAT_SIZE-1:0] brat_vec;
  } cdb_packet_t;

  // A packet dies when it depends on any of the mispredicted branch tags.
  function automatic logic is_squashed(input logic [BRAT_SIZE-1:0] vec,
                                       input logic [BRAT_SIZE-1:0] mask);
    return |(vec & mask);
  endfunction

endpackage

// File: rtl/complete_stage_cdb_fifo.sv
// Per-source result FIFO with in-place squash compaction and branch-tag clearing.
module cdb_fifo
  import complete_stage_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push_i,
  input  ex_packet_t           pkt_i,
  input  logic                 pop_i,
  input  logic [BRAT_SIZE-1:0] squash_mask_i,
  input  logic [BRAT_SIZE-1:0] clear_mask_i,
  output ex_packet_t           head_o,
  output logic                 empty_o,
  output logic [PTR_W-1:0]     free_cnt_o
);

  ex_packet_t         mem_q [FIFO_DEPTH];
  ex_packet_t         mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   used;
  logic [PTR_W-1:0]   keep;
  logic [PTR_W:0]     new_used;
  logic [ADDR_W-1:0]  idx;
  logic               push_ok;
  ex_packet_t         ent;

  assign used       = wr_ptr_q - rd_ptr_q;
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign head_o     = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign free_cnt_o = PTR_W'(FIFO_DEPTH) - used;

  // Rebuild the queue: drop the popped head and squashed entries, keep survivor order, append the push.
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
    keep     = '0;
    idx      = '0;
    ent      = '0;
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    for (int j = 0; j < FIFO_DEPTH; j++) begin
      idx = rd_ptr_q[ADDR_W-1:0] + ADDR_W'(j);
      ent = mem_q[idx];
      if ((PTR_W'(j) < used) && !((j == 0) && pop_i) &&
          !is_squashed(ent.brat_vec, squash_mask_i)) begin
        ent.brat_vec = ent.brat_vec & ~clear_mask_i;
        mem_d[rd_ptr_d[ADDR_W-1:0] + keep[ADDR_W-1:0]] = ent;
        keep = keep + PTR_W'(1);
      end
    end
    push_ok = push_i && pkt_i.valid && !is_squashed(pkt_i.brat_vec, squash_mask_i);
    if (push_ok) begin
      ent          = pkt_i;
      ent.brat_vec = pkt_i.brat_vec & ~clear_mask_i;
      mem_d[rd_ptr_d[ADDR_W-1:0] + keep[ADDR_W-1:0]] = ent;
    end
    wr_ptr_d = rd_ptr_d + keep + PTR_W'(push_ok);
    new_used = {1'b0, keep} + (PTR_W+1)'(push_ok);
  end

  // Pointer state; an asynchronous reset discards everything buffered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Payload storage needs no reset; only entries between the pointers are meaningful.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  // Issue back-pressure must make overflow impossible.
  overflow_chk: assert property (@(posedge clock) disable iff (!reset)
                                 new_used <= (PTR_W+1)'(FIFO_DEPTH));

endmodule

// File: rtl/complete_stage.sv
// Completion stage: buffers EX results per source, arbitrates onto the CDB, drives issue stalls.
module complete_stage
  import complete_stage_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  ex_packet_t           ex_pkt_in [NUM_SRC],
  input  logic                 brat_mis_valid,
  input  logic [BRAT_SIZE-1:0] brat_mis,
  input  logic                 brat_correct_valid,
  input  logic [BRAT_SIZE-1:0] brat_correct,
  output cdb_packet_t          cdb_pkt_out [CDB_WIDTH],
  output logic                 issue_stall_1,
  output logic                 issue_stall_2
);

  logic [BRAT_SIZE-1:0] squash_mask, clear_mask;
  ex_packet_t           head     [NUM_SRC];
  logic [PTR_W-1:0]     free_cnt [NUM_SRC];
  logic [NUM_SRC-1:0]   empty, cand, grant;

  logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d, src;
  logic [SRC_W-1:0]     slot_src [CDB_WIDTH];
  logic [CDB_WIDTH-1:0] slot_vld;
  logic [GNT_W-1:0]     gnt_cnt;

  cdb_packet_t          cdb_q [CDB_WIDTH];
  cdb_packet_t          cdb_d [CDB_WIDTH];

  logic                 stall1_raw, stall2_raw;
  logic                 stall2_q, lane1_gnt_q;

  assign squash_mask = brat_mis_valid     ? brat_mis     : '0;
  assign clear_mask  = brat_correct_valid ? brat_correct : '0;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      cdb_fifo u_fifo (
        .clock         (clock),
        .reset         (reset),
        .push_i        (ex_pkt_in[gi].valid),
        .pkt_i         (ex_pkt_in[gi]),
        .pop_i         (grant[gi]),
        .squash_mask_i (squash_mask),
        .clear_mask_i  (clear_mask),
        .head_o        (head[gi]),
        .empty_o       (empty[gi]),
        .free_cnt_o    (free_cnt[gi])
      );
      // A head killed by this cycle's mispredict may not compete.
      assign cand[gi] = !empty[gi] && head[gi].valid &&
                        !is_squashed(head[gi].brat_vec, squash_mask);
    end
  endgenerate

  // Round-robin from rr_ptr: the first CDB_WIDTH live heads win, grant k feeds slot k.
  always_comb begin
    grant    = '0;
    slot_vld = '0;
    gnt_cnt  = '0;
    src      = '0;
    rr_ptr_d = rr_ptr_q;
    for (int sl = 0; sl < CDB_WIDTH; sl++) slot_src[sl] = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      src = rr_ptr_q + SRC_W'(k);
      if (cand[src] && (gnt_cnt < GNT_W'(CDB_WIDTH))) begin
        grant[src] = 1'b1;
        for (int sl = 0; sl < CDB_WIDTH; sl++) begin
          if (gnt_cnt == GNT_W'(sl)) begin
            slot_src[sl] = src;
            slot_vld[sl] = 1'b1;
          end
        end
        gnt_cnt  = gnt_cnt + GNT_W'(1);
        rr_ptr_d = src + SRC_W'(1);
      end
    end
  end

  // Next broadcast: granted heads with any branch tag resolved this cycle already cleared.
  always_comb begin
    for (int sl = 0; sl < CDB_WIDTH; sl++) begin
      cdb_d[sl] = '0;
      if (slot_vld[sl]) begin
        cdb_d[sl].valid    = 1'b1;
        cdb_d[sl].result   = head[slot_src[sl]].result;
        cdb_d[sl].dest_prn = head[slot_src[sl]].dest_prn;
        cdb_d[sl].brat_vec = head[slot_src[sl]].brat_vec & ~clear_mask;
      end
    end
  end

  // Output register, arbiter pointer and stall history.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int sl = 0; sl < CDB_WIDTH; sl++) cdb_q[sl] <= '0;
      rr_ptr_q    <= '0;
      stall2_q    <= 1'b0;
      lane1_gnt_q <= 1'b0;
    end else begin
      for (int sl = 0; sl < CDB_WIDTH; sl++) cdb_q[sl] <= cdb_d[sl];
      rr_ptr_q    <= rr_ptr_d;
      stall2_q    <= issue_stall_2;
      lane1_gnt_q <= grant[0] | grant[1];
    end
  end

  assign cdb_pkt_out = cdb_q;

  // Non_mul FIFOs need room for one more result; mul FIFOs keep room for queued multiplies.
  assign stall1_raw = (free_cnt[0] < PTR_W'(2)) || (free_cnt[1] <= PTR_W'(MUL_RESERVE));
  assign stall2_raw = (free_cnt[2] < PTR_W'(2)) || (free_cnt[3] <= PTR_W'(MUL_RESERVE));

  assign issue_stall_1 = stall1_raw;
  // Lane2 keeps its stall while lane1 is the one being served on the bus.
  assign issue_stall_2 = stall2_raw || (stall2_q && lane1_gnt_q);

endmodule

// File: tb/tb_complete_stage.sv
// Directed bench for complete_stage: latency, arbitration, squash, tag clear, stall, async reset.
module tb_complete_stage;
  import complete_stage_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  ex_packet_t           ex_pkt_in [NUM_SRC];
  logic                 brat_mis_valid;
  logic [BRAT_SIZE-1:0] brat_mis;
  logic                 brat_correct_valid;
  logic [BRAT_SIZE-1:0] brat_correct;
  cdb_packet_t          cdb_pkt_out [CDB_WIDTH];
  logic                 issue_stall_1, issue_stall_2;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;

  complete_stage dut (
    .clock              (clock),
    .reset              (reset),
    .ex_pkt_in          (ex_pkt_in),
    .brat_mis_valid     (brat_mis_valid),
    .brat_mis           (brat_mis),
    .brat_correct_valid (brat_correct_valid),
    .brat_correct       (brat_correct),
    .cdb_pkt_out        (cdb_pkt_out),
    .issue_stall_1      (issue_stall_1),
    .issue_stall_2      (issue_stall_2)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    for (int s = 0; s < NUM_SRC; s++) ex_pkt_in[s] = '0;
    brat_mis_valid     = 1'b0;
    brat_mis           = '0;
    brat_correct_valid = 1'b0;
    brat_correct       = '0;
  endtask

  task automatic drive(input int s, input int res, input logic [BRAT_SIZE-1:0] brat);
    ex_pkt_in[s].valid    = 1'b1;
    ex_pkt_in[s].result   = 32'(res);
    ex_pkt_in[s].dest_prn = PRN_W'(s);
    ex_pkt_in[s].brat_vec = brat;
  endtask

  // One clock edge; outputs are sampled 1ns later and inputs are then released.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    for (int sl = 0; sl < CDB_WIDTH; sl++)
      if (cdb_pkt_out[sl].valid)
        $display("cyc %0d cdb slot%0d result=%0d prn=%0d brat=%b", cyc, sl,
                 cdb_pkt_out[sl].result, cdb_pkt_out[sl].dest_prn, cdb_pkt_out[sl].brat_vec);
    clear_inputs();
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic check_slot(input string tag, input int sl, input logic v, input int res);
    check({tag, ".valid"}, cdb_pkt_out[sl].valid, v);
    if (v) check({tag, ".result"}, cdb_pkt_out[sl].result, 64'(res));
  endtask

  initial begin
    clear_inputs();
    #1 reset = 1'b0;
    #1;
    check("rst.slot0", cdb_pkt_out[0].valid, 0);
    check("rst.slot1", cdb_pkt_out[1].valid, 0);
    check("rst.stall1", issue_stall_1, 0);
    check("rst.stall2", issue_stall_2, 0);
    @(negedge clock);
    reset = 1'b1;

    // Single source: no bypass, broadcast two edges after capture.
    drive(0, 5, 3'b000);
    tick();
    check_slot("single.e1.s0", 0, 1'b0, 0);
    tick();
    check_slot("single.e2.s0", 0, 1'b1, 5);
    check_slot("single.e2.s1", 1, 1'b0, 0);
    check("single.e2.prn", cdb_pkt_out[0].dest_prn, 0);
    tick();
    check_slot("single.e3.s0", 0, 1'b0, 0);

    // Four sources at once, rr_ptr starts at 0.
    do_reset();
    for (int s = 0; s < NUM_SRC; s++) drive(s, s + 1, 3'b000);
    tick();
    check_slot("four.e1.s0", 0, 1'b0, 0);
    tick();
    check_slot("four.e2.s0", 0, 1'b1, 1);
    check_slot("four.e2.s1", 1, 1'b1, 2);
    tick();
    check_slot("four.e3.s0", 0, 1'b1, 3);
    check_slot("four.e3.s1", 1, 1'b1, 4);
    tick();
    check_slot("four.e4.s0", 0, 1'b0, 0);
    check_slot("four.e4.s1", 1, 1'b0, 0);

    // Squash: FIFO0 holds 001,010 with 000 arriving as brat_mis=010 pulses.
    do_reset();
    drive(1, 50, 3'b000);
    tick();
    drive(0, 10, 3'b001);
    drive(2, 60, 3'b000);
    drive(3, 70, 3'b000);
    tick();
    check_slot("sq.e2.s0", 0, 1'b1, 50);
    check_slot("sq.e2.s1", 1, 1'b0, 0);
    drive(0, 20, 3'b010);
    tick();
    check_slot("sq.e3.s0", 0, 1'b1, 60);
    check_slot("sq.e3.s1", 1, 1'b1, 70);
    drive(0, 30, 3'b000);
    drive(2, 99, 3'b010);
    brat_mis_valid = 1'b1;
    brat_mis       = 3'b010;
    tick();
    check_slot("sq.e4.s0", 0, 1'b1, 10);
    check("sq.e4.brat", cdb_pkt_out[0].brat_vec, 3'b001);
    check_slot("sq.e4.s1", 1, 1'b0, 0);
    tick();
    check_slot("sq.e5.s0", 0, 1'b1, 30);
    check_slot("sq.e5.s1", 1, 1'b0, 0);
    tick();
    check_slot("sq.e6.s0", 0, 1'b0, 0);
    check_slot("sq.e6.s1", 1, 1'b0, 0);

    // Correct resolution clears tag 001; a later mispredict on 001 spares it.
    do_reset();
    drive(0, 40, 3'b011);
    brat_correct_valid = 1'b1;
    brat_correct       = 3'b001;
    tick();
    drive(1, 41, 3'b001);
    brat_mis_valid = 1'b1;
    brat_mis       = 3'b001;
    tick();
    check_slot("corr.e2.s0", 0, 1'b1, 40);
    check("corr.e2.brat", cdb_pkt_out[0].brat_vec, 3'b010);
    check_slot("corr.e2.s1", 1, 1'b0, 0);
    tick();
    check_slot("corr.e3.s0", 0, 1'b0, 0);
    check_slot("corr.e3.s1", 1, 1'b0, 0);

    // Back-pressure: sources 0,2,3 stream; FIFO0 reaches 7 used after edge 19,
    // FIFO3 reaches 4 used after edge 8.
    do_reset();
    for (int n = 1; n <= 19; n++) begin
      drive(0, 100 + n, 3'b000);
      drive(2, 200 + n, 3'b000);
      drive(3, 300 + n, 3'b000);
      tick();
      check($sformatf("bp.stall1.n%0d", n), issue_stall_1, (n >= 19) ? 1 : 0);
      check($sformatf("bp.stall2.n%0d", n), issue_stall_2, (n >= 8) ? 1 : 0);
    end
    check("bp.slot0", cdb_pkt_out[0].valid, 1);
    check("bp.slot1", cdb_pkt_out[1].valid, 1);

    // Asynchronous reset while the FIFOs are loaded, between clock edges.
    #3 reset = 1'b0;
    #1;
    check("arst.slot0", cdb_pkt_out[0].valid, 0);
    check("arst.slot1", cdb_pkt_out[1].valid, 0);
    check("arst.stall1", issue_stall_1, 0);
    check("arst.stall2", issue_stall_2, 0);
    @(negedge clock);
    reset = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      tick();
      check($sformatf("arst.post%0d.s0", n), cdb_pkt_out[0].valid, 0);
      check($sformatf("arst.post%0d.s1", n), cdb_pkt_out[1].valid, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
